// File: rtl/sipo_if.sv
// Chunk-in / word-out handshake bundle for the sipo reassembly block.
// master: the side that drives chunks and accepts words (link + datapath).
// slave: the sipo block itself.
interface sipo_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
);
  logic [IN_WIDTH-1:0]  i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic [OUT_WIDTH-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_partial;

  modport master (
    output i_data,
    output i_valid,
    output i_ready,
    input  o_ready,
    input  o_data,
    input  o_valid,
    input  o_partial
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_ready,
    output o_ready,
    output o_data,
    output o_valid,
    output o_partial
  );
endinterface

// File: rtl/sipo.sv
// Purpose: packs N_CHUNKS narrow chunks (first chunk in the MSBs) into one registered output word.
// Latency: o_valid rises one cycle after the final chunk is accepted; one word per N_CHUNKS cycles at full rate.
// Backpressure: non-final chunks are always accepted; the final chunk waits until the held word is taken.
module sipo #(
  parameter int IN_WIDTH  = 8,
  parameter int N_CHUNKS  = 4,
  parameter int OUT_WIDTH = IN_WIDTH * N_CHUNKS
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_flush,
  sipo_if.slave bus
);

  localparam int              IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  logic [IDX_W-1:0]     idx_q;
  logic                 last_chunk;
  logic                 accept;
  logic [OUT_WIDTH-1:0] word_next;
  logic [OUT_WIDTH-1:0] data_q;
  logic                 valid_q;

  // With a single chunk per word idx never leaves 0, so every chunk is final.
  assign last_chunk = (idx_q == LAST_IDX);

  // Only the final chunk has to wait for the output register to free up;
  // earlier chunks go into the assembly buffer while the old word is held.
  assign bus.o_ready = last_chunk ? (!valid_q || bus.i_ready) : 1'b1;
  assign accept      = bus.i_valid && bus.o_ready;

  // Chunk position counter: advances per non-final chunk, wraps on the final one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q <= '0;
    end else if (i_flush) begin
      idx_q <= '0;
    end else if (accept) begin
      if (last_chunk) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  generate
    if (N_CHUNKS > 1) begin : g_asm
      localparam int ASM_W = (N_CHUNKS - 1) * IN_WIDTH;

      logic [ASM_W-1:0] asm_q;

      // Assembly buffer: slot k sits k chunks down from the MSB end. It is not
      // cleared after a word completes; the next word overwrites every slot.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          asm_q <= '0;
        end else if (i_flush) begin
          asm_q <= '0;
        end else if (accept && !last_chunk) begin
          for (int k = 0; k < N_CHUNKS - 1; k++) begin
            if (idx_q == IDX_W'(k)) begin
              asm_q[ASM_W-1-k*IN_WIDTH -: IN_WIDTH] <= bus.i_data;
            end
          end
        end
      end

      assign word_next = {asm_q, bus.i_data};
    end else begin : g_single
      assign word_next = bus.i_data;
    end
  endgenerate

  // Output register: a final accept loads a new word (replacing a word being
  // taken the same cycle, for back-to-back throughput); otherwise a take
  // simply drops valid and leaves the data in place.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (i_flush) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (accept && last_chunk) begin
      data_q  <= word_next;
      valid_q <= 1'b1;
    end else if (valid_q && bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_partial = (idx_q != '0);

endmodule

// File: tb/tb_sipo.sv
// Directed bench for sipo: a default 4x8 instance and a single-chunk 1x8 instance.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Every expected value below is hand-derived from the block's behaviour.
module tb_sipo;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic flush4;
  logic flush1;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  sipo_if #(.IN_WIDTH(8), .OUT_WIDTH(32)) bus4 ();
  sipo_if #(.IN_WIDTH(8), .OUT_WIDTH(8))  bus1 ();

  sipo #(.IN_WIDTH(8), .N_CHUNKS(4), .OUT_WIDTH(32)) dut4 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (flush4),
    .bus     (bus4.slave)
  );

  sipo #(.IN_WIDTH(8), .N_CHUNKS(1), .OUT_WIDTH(8)) dut1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (flush1),
    .bus     (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Four chunks MSB first, one per cycle; leaves i_valid low afterwards.
  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      bus4.i_data  = w[31-8*i -: 8];
      bus4.i_valid = 1'b1;
      cyc();
    end
    bus4.i_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [7:0]  b0;

    i_rst_n      = 1'b0;
    flush4       = 1'b0;
    flush1       = 1'b0;
    bus4.i_data  = '0;
    bus4.i_valid = 1'b0;
    bus4.i_ready = 1'b0;
    bus1.i_data  = '0;
    bus1.i_valid = 1'b0;
    bus1.i_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_valid",   32'(bus4.o_valid),   32'd0);
    chk("rst_data",    bus4.o_data,         32'd0);
    chk("rst_partial", 32'(bus4.o_partial), 32'd0);
    chk("rst_ready",   32'(bus4.o_ready),   32'd1);
    chk("rst1_ready",  32'(bus1.o_ready),   32'd1);
    chk("rst1_valid",  32'(bus1.o_valid),   32'd0);
    #11;
    i_rst_n = 1'b1;
    cyc();

    // Basic assembly: 11 22 33 44 -> 11223344, valid for one cycle
    bus4.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.i_data  = 8'(17 * (i + 1));
      bus4.i_valid = 1'b1;
      #1;
      chk("basic_ready", 32'(bus4.o_ready), 32'd1);
      cyc();
      chk("basic_partial", 32'(bus4.o_partial), (i < 3) ? 32'd1 : 32'd0);
      chk("basic_valid",   32'(bus4.o_valid),   (i == 3) ? 32'd1 : 32'd0);
    end
    chk("basic_data", bus4.o_data, 32'h11223344);
    bus4.i_valid = 1'b0;
    cyc();
    chk("basic_pulse_end", 32'(bus4.o_valid), 32'd0);
    chk("basic_data_hold", bus4.o_data, 32'h11223344);

    // Backpressure overlap: word held, AA..CC accepted, DD stalls
    bus4.i_ready = 1'b0;
    send4(32'h11223344);
    chk("bp_held_valid", 32'(bus4.o_valid), 32'd1);
    chk("bp_held_data",  bus4.o_data, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      bus4.i_data  = 8'(8'hAA + 17 * i);
      bus4.i_valid = 1'b1;
      #1;
      chk("bp_ready_nonfinal", 32'(bus4.o_ready), 32'd1);
      cyc();
      chk("bp_valid_stable", 32'(bus4.o_valid), 32'd1);
      chk("bp_data_stable",  bus4.o_data, 32'h11223344);
    end
    bus4.i_data = 8'hDD;
    #1;
    chk("bp_ready_final_stall", 32'(bus4.o_ready), 32'd0);
    cyc();
    chk("bp_stall_valid",   32'(bus4.o_valid),   32'd1);
    chk("bp_stall_data",    bus4.o_data,         32'h11223344);
    chk("bp_stall_partial", 32'(bus4.o_partial), 32'd1);
    bus4.i_ready = 1'b1;
    #1;
    chk("bp_ready_release", 32'(bus4.o_ready), 32'd1);
    cyc();
    chk("bp_swap_valid",   32'(bus4.o_valid),   32'd1);
    chk("bp_swap_data",    bus4.o_data,         32'hAABBCCDD);
    chk("bp_swap_partial", 32'(bus4.o_partial), 32'd0);
    bus4.i_valid = 1'b0;
    cyc();
    chk("bp_taken_valid", 32'(bus4.o_valid), 32'd0);
    chk("bp_taken_hold",  bus4.o_data, 32'hAABBCCDD);

    // Streaming: A0..AF continuously, a word every 4th cycle, no stalls
    for (int i = 0; i < 16; i++) begin
      bus4.i_data  = 8'(8'hA0 + i);
      bus4.i_valid = 1'b1;
      #1;
      chk("stream_ready", 32'(bus4.o_ready), 32'd1);
      cyc();
      chk("stream_valid", 32'(bus4.o_valid), (i % 4 == 3) ? 32'd1 : 32'd0);
      if (i % 4 == 3) begin
        b0    = 8'(8'hA0 + 4 * (i / 4));
        exp_w = {b0, 8'(b0 + 1), 8'(b0 + 2), 8'(b0 + 3)};
        chk("stream_data", bus4.o_data, exp_w);
      end
    end
    bus4.i_valid = 1'b0;
    cyc();
    chk("stream_end_valid", 32'(bus4.o_valid), 32'd0);

    // Flush mid-assembly, with a chunk presented in the flush cycle
    bus4.i_data  = 8'hEE;
    bus4.i_valid = 1'b1;
    cyc();
    bus4.i_data = 8'hFF;
    cyc();
    chk("flush_pre_partial", 32'(bus4.o_partial), 32'd1);
    bus4.i_data = 8'h77;
    flush4      = 1'b1;
    cyc();
    flush4       = 1'b0;
    bus4.i_valid = 1'b0;
    chk("flush_partial", 32'(bus4.o_partial), 32'd0);
    chk("flush_valid",   32'(bus4.o_valid),   32'd0);
    send4(32'h01020304);
    chk("flush_next_valid", 32'(bus4.o_valid), 32'd1);
    chk("flush_next_data",  bus4.o_data, 32'h01020304);

    // Flush while a word is held
    bus4.i_ready = 1'b0;
    flush4       = 1'b1;
    cyc();
    flush4 = 1'b0;
    chk("flush_out_valid", 32'(bus4.o_valid), 32'd0);
    chk("flush_out_data",  bus4.o_data, 32'd0);
    bus4.i_ready = 1'b1;

    // Async reset mid-assembly, between clock edges
    bus4.i_data  = 8'h12;
    bus4.i_valid = 1'b1;
    cyc();
    bus4.i_data = 8'h34;
    cyc();
    bus4.i_valid = 1'b0;
    chk("arst_pre_partial", 32'(bus4.o_partial), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_partial", 32'(bus4.o_partial), 32'd0);
    chk("arst_ready",   32'(bus4.o_ready),   32'd1);
    #1;
    i_rst_n = 1'b1;
    cyc();

    // Async reset while a word is held
    send4(32'h9ABCDEF0);
    chk("arst2_pre_valid", 32'(bus4.o_valid), 32'd1);
    bus4.i_ready = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst2_valid",   32'(bus4.o_valid),   32'd0);
    chk("arst2_data",    bus4.o_data,         32'd0);
    chk("arst2_partial", 32'(bus4.o_partial), 32'd0);
    #1;
    i_rst_n      = 1'b1;
    bus4.i_ready = 1'b1;
    cyc();
    send4(32'h55667788);
    chk("arst_after_valid", 32'(bus4.o_valid), 32'd1);
    chk("arst_after_data",  bus4.o_data, 32'h55667788);
    cyc();
    chk("arst_after_taken", 32'(bus4.o_valid), 32'd0);

    // Single-chunk instance: one-deep registered stage
    bus1.i_ready = 1'b1;
    bus1.i_data  = 8'h5A;
    bus1.i_valid = 1'b1;
    #1;
    chk("n1_ready_empty", 32'(bus1.o_ready), 32'd1);
    chk("n1_partial",     32'(bus1.o_partial), 32'd0);
    cyc();
    chk("n1_valid", 32'(bus1.o_valid), 32'd1);
    chk("n1_data",  32'(bus1.o_data),  32'h5A);
    bus1.i_ready = 1'b0;
    bus1.i_data  = 8'h3C;
    #1;
    chk("n1_ready_blocked", 32'(bus1.o_ready), 32'd0);
    cyc();
    chk("n1_data_hold", 32'(bus1.o_data), 32'h5A);
    bus1.i_ready = 1'b1;
    #1;
    chk("n1_ready_release", 32'(bus1.o_ready), 32'd1);
    cyc();
    chk("n1_data_next",  32'(bus1.o_data),  32'h3C);
    chk("n1_valid_next", 32'(bus1.o_valid), 32'd1);
    bus1.i_valid = 1'b0;
    cyc();
    chk("n1_valid_drop", 32'(bus1.o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo.md
# sipo

Serial-in/parallel-out reassembly block. It accepts `OUT_WIDTH`-bit words... rather, it accepts `IN_WIDTH`-bit chunks over a valid/ready handshake and packs `N_CHUNKS` consecutive chunks, MSB first, into one `OUT_WIDTH`-bit word. It then presents that word on a registered valid/ready output. It is the receive-side counterpart of the chunk serializer: it sits at the far end of a narrow link and restores the full-width word for downstream datapath logic.

## Interface
- `IN_WIDTH`, default 8: width of one chunk.
- `N_CHUNKS`, default 4: chunks per assembled word; legal values are ≥ 1.
- `OUT_WIDTH`, default `IN_WIDTH * N_CHUNKS`: assembled word width; must equal `IN_WIDTH * N_CHUNKS`.
- `i_clk`, input, 1: clock; all state changes on the rising edge.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_flush`, input, 1: synchronous discard of partial assembly and pending output.
- `i_data`, input, `IN_WIDTH`: incoming chunk.
- `i_valid`, input, 1: chunk valid.
- `o_ready`, output, 1: block can accept a chunk this cycle.
- `o_data`, output, `OUT_WIDTH`: assembled word, registered.
- `o_valid`, output, 1: `o_data` holds a complete word.
- `i_ready`, input, 1: downstream accepts the word.
- `o_partial`, output, 1: assembly buffer holds ≥ 1 but < `N_CHUNKS` chunks.

## Operation
- **State**
  - Assembly buffer `(N_CHUNKS-1)*IN_WIDTH` bits.
  - Chunk counter `idx`, width `max(1, $clog2(N_CHUNKS))`, range 0..`N_CHUNKS`-1.
  - Output register `o_data`/`o_valid`.
- **Input acceptance.** A chunk is accepted when `i_valid && o_ready`.
- **`o_ready`**
  - Non-final chunk (`idx < N_CHUNKS-1`): `o_ready = 1`. Assembly of the next word overlaps holding of the current word.
  - Final chunk (`idx == N_CHUNKS-1`): `o_ready = !o_valid || i_ready`.
  - `o_ready` is combinational from `i_ready` only on the final chunk.
- **Non-final accept.** The chunk is written to buffer slot `idx`. Slot 0 maps to the MSBs, bits `[OUT_WIDTH-1 -: IN_WIDTH]`. Then `idx <= idx+1`.
- **Final accept**
  - `o_data <= {buffer, i_data}`; the last chunk lands in the LSBs.
  - `o_valid <= 1` and `idx <= 0`.
  - The buffer is not cleared; stale contents are overwritten by the next word.
- **Output handshake.**
  - On `o_valid && i_ready` with no simultaneous final accept: `o_valid <= 0`, and `o_data` holds its value.
  - On a simultaneous final accept in the same cycle, the new word replaces the old one and `o_valid` stays 1. This gives back-to-back full throughput.
- **`N_CHUNKS == 1`.** Every chunk is final; the buffer is zero width. Behaviour is a one-deep registered stage with `o_ready = !o_valid || i_ready`.
- **`o_partial`** is `idx != 0`, which is registered state only.
- **Flush**
  - `i_flush` has priority over all handshakes in that cycle.
  - It sets `idx <= 0`, `o_valid <= 0`, `o_data <= 0`, buffer `<= 0`.
  - Any chunk presented that cycle is dropped. `o_ready` is still computed normally, so an upstream handshake may complete and lose its data; upstream must not rely on it.
  - A word consumed that cycle is also considered discarded.

## Timing
- **Reset values** (asynchronous on `i_rst_n` low): `o_valid = 0`, `o_data = 0`, `o_partial = 0`, `idx = 0`, buffer = 0.
  - `o_ready` = 1 out of reset.
  - Reset mid-assembly discards everything immediately; no cycle is needed.
- **Latency.** `o_valid` rises the cycle after the final chunk is accepted. Minimum word period is `N_CHUNKS` cycles with `i_valid` and `i_ready` held high.
- **Backpressure.** With `o_valid` held by `i_ready = 0`, up to `N_CHUNKS-1` further chunks are accepted. Then `o_ready` drops until the word is taken.
- `o_data` is stable while `o_valid && !i_ready`.
- **Wrap-around.** `idx` returns to 0 only via final accept, flush, or reset; it never exceeds `N_CHUNKS-1`.

## Test plan
- **Basic assembly.** Defaults, `i_ready = 1`; send 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Expect `o_data = 0x11223344` with `o_valid` high for exactly 1 cycle, starting the cycle after 0x44.
  - Expect `o_partial` high for 3 cycles.
- **Backpressure overlap.** `i_ready = 0` after word 0x11223344; send 0xAA, 0xBB, 0xCC, 0xDD.
  - 0xAA–0xCC are accepted and `o_ready` drops at 0xDD.
  - Raise `i_ready`: 0xDD is accepted that cycle, and the next cycle `o_data = 0xAABBCCDD` with `o_valid` still 1.
- **Streaming.** 4 words back-to-back with continuous valid and ready.
  - Expect 4 words, each `o_valid` pulse 4 cycles apart, and zero stall cycles on `o_ready`.
- **Flush.**
  - After 2 chunks, pulse `i_flush`: `o_partial -> 0`. The next 4 chunks 0x01..0x04 give 0x01020304, with no stale bytes.
  - Flush while `o_valid = 1` and `i_ready = 0`: `o_valid -> 0` and `o_data -> 0`.
- **Async reset.** Assert `i_rst_n = 0` between clock edges mid-assembly and with `o_valid = 1`.
  - All outputs go to their reset values before the next edge.
  - After release, 4 chunks produce a correct word.
- **`N_CHUNKS = 1`, `IN_WIDTH = 8`.**
  - Chunk 0x5A produces `o_data = 0x5A` one cycle later.
  - With `i_ready = 0` and `o_valid = 1`, `o_ready = 0`.
